prt_scaler_lbf_mc: RTL and testbench
====================================

# prt_scaler_lbf_mc

Multi-channel output line buffer for the scaler datapath: accepts kernel output words for P_CH colour channels, holds them in a single shared FIFO, and releases them against the timing generator's data enable. Sits between the kernels and the video output mux, and replaces the per-channel line buffer instances with one generalised block. Compared with the per-channel buffer it adds:

- parametrised channel count and depth;
- a programmable start threshold;
- back-pressure slack;
- optional sticky underflow/overflow status.

## Interface
Parameters:
- P_VENDOR, "none", RAM vendor selection ("xilinx", "lattice", "none").
- P_PPC, 4, pixels per clock.
- P_BPC, 8, bits per component.
- P_CH, 3, colour channels, 1..4.
- P_DEPTH, 1024, FIFO words; power of two, ≥ 16.
- P_SLACK, 8, free words required for ready; < P_DEPTH.

Ports:
- Clock and reset:
  - CLK_IN  in  1  video clock; one clock domain.
  - RST_IN  in  1  reset; asynchronous, active-high.
- Control:
  - CTL_RUN_IN  in  1  run enable.
  - CTL_FS_IN  in  1  frame start (input vsync).
  - CTL_THR_IN  in  $clog2(P_DEPTH)+1  start threshold in words; quasi-static.
- Flow control:
  - LBF_RDY_OUT  out  1  free words ≥ P_SLACK.
- Timing generator:
  - TG_VS_IN, TG_HS_IN, TG_DE_IN  in  1 each  timing generator syncs.
  - TG_RUN_OUT  out  1  start timing generator.
- Video in:
  - VID_DAT_IN  in  P_CH*P_PPC*P_BPC  kernel data; channel c at bits [c*P_PPC*P_BPC +: P_PPC*P_BPC].
  - VID_DE_IN  in  1  write strobe.
- Video out:
  - VID_VS_OUT, VID_HS_OUT, VID_DE_OUT  out  1 each  output syncs.
  - VID_DAT_OUT  out  P_CH*P_PPC*P_BPC  output data.
- Status:
  - STA_LVL_OUT  out  $clog2(P_DEPTH)+1  fill level.
  - STA_UFL_OUT, STA_OVF_OUT  out  1 each  sticky underflow/overflow flags.

## Operation
State machine, states IDLE, WAIT_FS, FILL, RUN:
- IDLE:
  - Pointers and level held at 0; writes ignored; TG_RUN_OUT=0.
  - CTL_RUN_IN=1 → WAIT_FS.
- WAIT_FS:
  - Writes ignored; status flags cleared on entry.
  - CTL_FS_IN=1 → FILL. Writes are accepted from the same cycle.
- FILL:
  - Writes accepted; no reads.
  - level ≥ CTL_THR_IN → RUN.
  - CTL_THR_IN=0 is treated as 1.
  - CTL_THR_IN > P_DEPTH is saturated to P_DEPTH.
- RUN:
  - TG_RUN_OUT=1 (registered, asserted the cycle after entry).
  - Each TG_DE_IN=1 cycle pops one word.
  - CTL_FS_IN is ignored, so the frame runs continuously.
- CTL_RUN_IN=0 in any state → IDLE next cycle. This flushes the FIFO (pointers and level to 0) and deasserts TG_RUN_OUT.

Data rules:
- Write, full: word dropped, STA_OVF_OUT set.
- Read, empty: VID_DAT_OUT=0, VID_DE_OUT still follows TG_DE_IN, STA_UFL_OUT set. Pointers do not move.
- Simultaneous write and read: level unchanged.
- Simultaneous write and read on an empty FIFO: counts as underflow. The written word is stored; there is no bypass.
- Pointers are $clog2(P_DEPTH) bits and wrap naturally.
- Level is one bit wider so full and empty are distinguishable; full when level == P_DEPTH.
- LBF_RDY_OUT = (P_DEPTH − level) ≥ P_SLACK, registered. It is also 0 in IDLE and WAIT_FS.

## Timing
- Output latency: TG_* to VID_* is 2 cycles (RAM read register, then output register). VS/HS/DE are delayed through a matching 2-stage pipe.
- Write to readable: a word written in cycle n counts in the level at n+1 and may be read from n+1.
- Reset values:
  - State IDLE.
  - All outputs 0, except VID_DAT_OUT=0 and STA_LVL_OUT=0.
- Reset mid-frame: asynchronous clear of state, pointers, level, flags and pipes. The RAM contents are not cleared.
- LBF_RDY_OUT reflects the level one cycle late, so the upstream agent must stop within P_SLACK−1 cycles.

## Configuration
- PRT_SCALER_LBF_MC_STA_EN:
  - Defined: STA_UFL_OUT, STA_OVF_OUT and STA_LVL_OUT are live as described above.
  - Undefined: all three outputs are tied to 0, and the sticky-flag logic is removed. FIFO behaviour (drop on full, zero on empty) is unchanged.

## Structure
- Shared package prt_scaler_pkg holds:
  - the enum typedef for the LBF states (IDLE, WAIT_FS, FILL, RUN);
  - a function computing the level width from a depth.
- Sub-module prt_scaler_lbf_ram:
  - simple dual-port RAM, width P_CH*P_PPC*P_BPC, depth P_DEPTH;
  - 1-cycle registered read;
  - vendor primitive selected by P_VENDOR, inferred RAM for "none".

## Test plan
- Threshold start: P_DEPTH=1024, CTL_THR_IN=64; assert run, pulse FS, write 64 words → RUN one cycle after the 64th write, TG_RUN_OUT=1 one cycle later. No read occurs before that.
- Data order and latency: write ramp 0..255 on all 3 channels, then drive TG_DE_IN for 256 cycles → VID_DAT_OUT is the ramp in order, 2 cycles after each TG_DE_IN, with VID_DE_OUT aligned.
- Underflow: in RUN with level 0, TG_DE_IN=1 for 4 cycles → VID_DAT_OUT=0 for those words, STA_UFL_OUT=1 and sticky until the next WAIT_FS.
- Overflow and ready: write 1024 words with no reads → LBF_RDY_OUT falls when level reaches 1017. The 1025th write is dropped, STA_OVF_OUT=1, level stays 1024.
- Run abort and reset: deassert CTL_RUN_IN mid-frame → IDLE, level 0, TG_RUN_OUT=0 next cycle. Assert RST_IN asynchronously mid-RUN → all outputs 0 immediately.
- Macro off: build without PRT_SCALER_LBF_MC_STA_EN and repeat the underflow test → STA_* stay 0 and data behaviour is identical.

Source files
------------

// File: rtl/prt_scaler_pkg.sv
// Shared scaler definitions: line-buffer FSM states and level-width helper.
package prt_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FS,
    FILL,
    RUN
  } lbf_state_t;

  // Level counts 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prt_scaler_lbf_ram.sv
// Simple dual-port line-buffer RAM, read-first, one-cycle registered read.
module prt_scaler_lbf_ram #(
  parameter string P_VENDOR = "none",
  parameter int    P_WIDTH  = 96,
  parameter int    P_DEPTH  = 1024,
  localparam int   AW       = $clog2(P_DEPTH)
) (
  input  logic               CLK_IN,
  input  logic               WR_EN_IN,
  input  logic [AW-1:0]      WR_ADDR_IN,
  input  logic [P_WIDTH-1:0] WR_DAT_IN,
  input  logic               RD_EN_IN,
  input  logic [AW-1:0]      RD_ADDR_IN,
  output logic [P_WIDTH-1:0] RD_DAT_OUT
);

  // Vendor block RAMs map their read-enable pin; the generic build free-runs
  // the read register since only enabled reads are ever consumed downstream.
  localparam bit RD_GATED = (P_VENDOR != "none");

  logic [P_WIDTH-1:0] mem [P_DEPTH];

  always_ff @(posedge CLK_IN) begin
    if (WR_EN_IN)
      mem[WR_ADDR_IN] <= WR_DAT_IN;
    if (RD_EN_IN || !RD_GATED)
      RD_DAT_OUT <= mem[RD_ADDR_IN];
  end

endmodule

// File: rtl/prt_scaler_lbf_mc.sv
// Multi-channel output line buffer: shared FIFO released against timing DE.
// Optional status outputs enabled by PRT_SCALER_LBF_MC_STA_EN.
module prt_scaler_lbf_mc
  import prt_scaler_pkg::*;
#(
  parameter string P_VENDOR = "none",
  parameter int    P_PPC    = 4,
  parameter int    P_BPC    = 8,
  parameter int    P_CH     = 3,
  parameter int    P_DEPTH  = 1024,
  parameter int    P_SLACK  = 8
) (
  input  logic                          CLK_IN,
  input  logic                          RST_IN,
  input  logic                          CTL_RUN_IN,
  input  logic                          CTL_FS_IN,
  input  logic [$clog2(P_DEPTH):0]      CTL_THR_IN,
  output logic                          LBF_RDY_OUT,
  input  logic                          TG_VS_IN,
  input  logic                          TG_HS_IN,
  input  logic                          TG_DE_IN,
  output logic                          TG_RUN_OUT,
  input  logic [P_CH*P_PPC*P_BPC-1:0]   VID_DAT_IN,
  input  logic                          VID_DE_IN,
  output logic                          VID_VS_OUT,
  output logic                          VID_HS_OUT,
  output logic                          VID_DE_OUT,
  output logic [P_CH*P_PPC*P_BPC-1:0]   VID_DAT_OUT,
  output logic [$clog2(P_DEPTH):0]      STA_LVL_OUT,
  output logic                          STA_UFL_OUT,
  output logic                          STA_OVF_OUT
);

  localparam int DW = P_CH * P_PPC * P_BPC;
  localparam int AW = $clog2(P_DEPTH);
  localparam int LW = lvl_width(P_DEPTH);

  lbf_state_t    state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, thr_eff;
  logic          full, empty, wr_allow, rd_req, rd_ok, wr_ok;
  logic [DW-1:0] ram_q;
  logic          s1_vld_reg, s1_vs_reg, s1_hs_reg, s1_de_reg;
  logic          vs_reg, hs_reg, de_reg, tg_run_reg, rdy_reg;
  logic [DW-1:0] dat_reg;

  always_comb begin
    thr_eff = CTL_THR_IN;
    if (CTL_THR_IN == '0)
      thr_eff = LW'(1);
    else if (CTL_THR_IN > LW'(P_DEPTH))
      thr_eff = LW'(P_DEPTH);
  end

  assign full     = (level_reg == LW'(P_DEPTH));
  assign empty    = (level_reg == '0);
  assign wr_allow = CTL_RUN_IN && ((state_reg == FILL) || (state_reg == RUN) ||
                                   ((state_reg == WAIT_FS) && CTL_FS_IN));
  assign rd_req   = CTL_RUN_IN && (state_reg == RUN) && TG_DE_IN;
  assign rd_ok    = rd_req && !empty;
  // A full FIFO still takes a word when a pop frees the slot in the same cycle.
  assign wr_ok    = wr_allow && VID_DE_IN && (!full || rd_ok);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (CTL_RUN_IN) state_next = WAIT_FS;
      WAIT_FS: if (CTL_FS_IN) state_next = FILL;
      FILL:    if (level_reg >= thr_eff) state_next = RUN;
      default: state_next = state_reg;
    endcase
    if (!CTL_RUN_IN)
      state_next = IDLE;
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (!CTL_RUN_IN || (state_reg == IDLE)) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (wr_ok && !rd_ok)
        level_reg <= level_reg + LW'(1);
      else if (rd_ok && !wr_ok)
        level_reg <= level_reg - LW'(1);
    end
  end

  prt_scaler_lbf_ram #(
    .P_VENDOR (P_VENDOR),
    .P_WIDTH  (DW),
    .P_DEPTH  (P_DEPTH)
  ) u_ram (
    .CLK_IN     (CLK_IN),
    .WR_EN_IN   (wr_ok),
    .WR_ADDR_IN (wr_ptr_reg),
    .WR_DAT_IN  (VID_DAT_IN),
    .RD_EN_IN   (rd_ok),
    .RD_ADDR_IN (rd_ptr_reg),
    .RD_DAT_OUT (ram_q)
  );

  // Stage 1 runs alongside the RAM read register; stage 2 is the output register.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      s1_vld_reg <= 1'b0;
      s1_vs_reg  <= 1'b0;
      s1_hs_reg  <= 1'b0;
      s1_de_reg  <= 1'b0;
      vs_reg     <= 1'b0;
      hs_reg     <= 1'b0;
      de_reg     <= 1'b0;
      dat_reg    <= '0;
      tg_run_reg <= 1'b0;
      rdy_reg    <= 1'b0;
    end else begin
      s1_vld_reg <= rd_ok;
      s1_vs_reg  <= TG_VS_IN;
      s1_hs_reg  <= TG_HS_IN;
      s1_de_reg  <= TG_DE_IN;
      vs_reg     <= s1_vs_reg;
      hs_reg     <= s1_hs_reg;
      de_reg     <= s1_de_reg;
      dat_reg    <= s1_vld_reg ? ram_q : '0;
      tg_run_reg <= CTL_RUN_IN && (state_reg == RUN);
      rdy_reg    <= ((state_next == FILL) || (state_next == RUN)) &&
                    ((LW'(P_DEPTH) - level_reg) >= LW'(P_SLACK));
    end
  end

  assign VID_VS_OUT  = vs_reg;
  assign VID_HS_OUT  = hs_reg;
  assign VID_DE_OUT  = de_reg;
  assign VID_DAT_OUT = dat_reg;
  assign TG_RUN_OUT  = tg_run_reg;
  assign LBF_RDY_OUT = rdy_reg;

`ifdef PRT_SCALER_LBF_MC_STA_EN
  logic ufl_reg, ovf_reg, ufl_evt, ovf_evt;

  assign ufl_evt = rd_req && empty;
  assign ovf_evt = wr_allow && VID_DE_IN && full && !rd_ok;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      ufl_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else if ((state_next == WAIT_FS) && (state_reg != WAIT_FS)) begin
      ufl_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (ufl_evt) ufl_reg <= 1'b1;
      if (ovf_evt) ovf_reg <= 1'b1;
    end
  end

  assign STA_LVL_OUT = level_reg;
  assign STA_UFL_OUT = ufl_reg;
  assign STA_OVF_OUT = ovf_reg;
`else
  assign STA_LVL_OUT = '0;
  assign STA_UFL_OUT = 1'b0;
  assign STA_OVF_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_prt_scaler_lbf_mc.sv
// Directed bench for prt_scaler_lbf_mc; status expectations follow PRT_SCALER_LBF_MC_STA_EN.
module tb_prt_scaler_lbf_mc;

  localparam int DW = 96;
  localparam int LW = 11;
`ifdef PRT_SCALER_LBF_MC_STA_EN
  localparam bit STA = 1'b1;
`else
  localparam bit STA = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          fs = 1'b0;
  logic [LW-1:0] thr = '0;
  logic          tg_vs = 1'b0, tg_hs = 1'b0, tg_de = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic          wde = 1'b0;
  logic          lbf_rdy, tg_run, q_vs, q_hs, q_de, sta_ufl, sta_ovf;
  logic [DW-1:0] q_dat;
  logic [LW-1:0] sta_lvl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prt_scaler_lbf_mc dut (
    .CLK_IN      (clk),
    .RST_IN      (rst),
    .CTL_RUN_IN  (run),
    .CTL_FS_IN   (fs),
    .CTL_THR_IN  (thr),
    .LBF_RDY_OUT (lbf_rdy),
    .TG_VS_IN    (tg_vs),
    .TG_HS_IN    (tg_hs),
    .TG_DE_IN    (tg_de),
    .TG_RUN_OUT  (tg_run),
    .VID_DAT_IN  (wdat),
    .VID_DE_IN   (wde),
    .VID_VS_OUT  (q_vs),
    .VID_HS_OUT  (q_hs),
    .VID_DE_OUT  (q_de),
    .VID_DAT_OUT (q_dat),
    .STA_LVL_OUT (sta_lvl),
    .STA_UFL_OUT (sta_ufl),
    .STA_OVF_OUT (sta_ovf)
  );

  // Distinct per-channel/per-pixel pattern for word v.
  function automatic logic [DW-1:0] mk(input int v);
    logic [15:0] b;
    b = 16'(v);
    return {b + 16'd2, 16'hC200, b + 16'd1, 16'hC100, b, 16'hC000};
  endfunction

  function automatic logic [LW-1:0] exp_lvl(input int n);
    return STA ? LW'(n) : '0;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick; tick;
    checks++; if (tg_run !== 1'b0) begin errors++; $display("FAIL rst_tg_run: got %b expected 0", tg_run); end
    checks++; if (lbf_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b expected 0", lbf_rdy); end
    checks++; if ({q_vs, q_hs, q_de} !== 3'b000) begin errors++; $display("FAIL rst_syncs: got %b expected 000", {q_vs, q_hs, q_de}); end
    checks++; if (q_dat !== '0) begin errors++; $display("FAIL rst_dat: got %h expected 0", q_dat); end
    checks++; if (sta_lvl !== '0) begin errors++; $display("FAIL rst_lvl: got %0d expected 0", sta_lvl); end
    checks++; if ({sta_ufl, sta_ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {sta_ufl, sta_ovf}); end
    rst = 1'b0;
    $display("tb: reset done");
  endtask

  task automatic test_threshold;
    thr = 11'd64;
    run = 1'b1;
    tick;
    checks++; if (lbf_rdy !== 1'b0) begin errors++; $display("FAIL thr_rdy_waitfs: got %b expected 0", lbf_rdy); end
    for (int k = 0; k < 64; k++) begin
      fs = (k == 0);
      wde = 1'b1;
      wdat = mk(k);
      tick;
      checks++; if (tg_run !== 1'b0) begin errors++; $display("FAIL thr_tg_run_early k=%0d: got %b expected 0", k, tg_run); end
    end
    fs = 1'b0;
    wde = 1'b0;
    checks++; if (sta_lvl !== exp_lvl(64)) begin errors++; $display("FAIL thr_lvl: got %0d expected %0d", sta_lvl, exp_lvl(64)); end
    checks++; if (q_de !== 1'b0) begin errors++; $display("FAIL thr_no_read: got %b expected 0", q_de); end
    tick;
    checks++; if (tg_run !== 1'b0) begin errors++; $display("FAIL thr_tg_run_entry: got %b expected 0", tg_run); end
    tick;
    checks++; if (tg_run !== 1'b1) begin errors++; $display("FAIL thr_tg_run_on: got %b expected 1", tg_run); end
    $display("tb: threshold start done");
  endtask

  task automatic test_data_order;
    int i;
    logic e_de, e_hs, e_vs;
    logic [DW-1:0] e_dat;
    for (int k = 64; k < 256; k++) begin
      wde = 1'b1;
      wdat = mk(k);
      tick;
    end
    wde = 1'b0;
    for (int c = 0; c < 258; c++) begin
      tg_de = (c < 256);
      tg_hs = (c < 256) && (c % 5 == 0);
      tg_vs = (c == 0);
      tick;
      i = c - 1;
      e_de  = (i >= 0) && (i < 256);
      e_hs  = (i >= 0) && (i < 256) && (i % 5 == 0);
      e_vs  = (i == 0);
      e_dat = e_de ? mk(i) : '0;
      checks++; if ({q_vs, q_hs, q_de} !== {e_vs, e_hs, e_de}) begin errors++; $display("FAIL data_syncs i=%0d: got %b expected %b", i, {q_vs, q_hs, q_de}, {e_vs, e_hs, e_de}); end
      checks++; if (q_dat !== e_dat) begin errors++; $display("FAIL data_word i=%0d: got %h expected %h", i, q_dat, e_dat); end
    end
    $display("tb: data order done");
  endtask

  task automatic test_underflow;
    logic e_de;
    for (int c = 0; c < 6; c++) begin
      tg_de = (c < 4);
      tick;
      e_de = (c >= 1) && (c <= 4);
      checks++; if (q_de !== e_de) begin errors++; $display("FAIL ufl_de c=%0d: got %b expected %b", c, q_de, e_de); end
      checks++; if (q_dat !== '0) begin errors++; $display("FAIL ufl_dat c=%0d: got %h expected 0", c, q_dat); end
    end
    checks++; if (sta_ufl !== STA) begin errors++; $display("FAIL ufl_flag: got %b expected %b", sta_ufl, STA); end
    checks++; if (sta_ovf !== 1'b0) begin errors++; $display("FAIL ufl_ovf_clear: got %b expected 0", sta_ovf); end
    tg_de = 1'b1;
    wde = 1'b1;
    wdat = mk(777);
    tick;
    tg_de = 1'b0;
    wde = 1'b0;
    tick;
    checks++; if ({q_de, q_dat} !== {1'b1, {DW{1'b0}}}) begin errors++; $display("FAIL ufl_simul: got de=%b dat=%h expected de=1 dat=0", q_de, q_dat); end
    checks++; if (sta_lvl !== exp_lvl(1)) begin errors++; $display("FAIL ufl_simul_lvl: got %0d expected %0d", sta_lvl, exp_lvl(1)); end
    tg_de = 1'b1;
    tick;
    tg_de = 1'b0;
    tick;
    checks++; if (q_dat !== mk(777)) begin errors++; $display("FAIL ufl_stored_word: got %h expected %h", q_dat, mk(777)); end
    checks++; if (sta_ufl !== STA) begin errors++; $display("FAIL ufl_sticky: got %b expected %b", sta_ufl, STA); end
    $display("tb: underflow done");
  endtask

  task automatic test_abort;
    for (int k = 0; k < 3; k++) begin
      wde = 1'b1;
      wdat = mk(900 + k);
      tick;
    end
    wde = 1'b0;
    checks++; if (sta_lvl !== exp_lvl(3)) begin errors++; $display("FAIL abort_lvl_before: got %0d expected %0d", sta_lvl, exp_lvl(3)); end
    run = 1'b0;
    tick;
    checks++; if (tg_run !== 1'b0) begin errors++; $display("FAIL abort_tg_run: got %b expected 0", tg_run); end
    checks++; if (lbf_rdy !== 1'b0) begin errors++; $display("FAIL abort_rdy: got %b expected 0", lbf_rdy); end
    checks++; if (sta_lvl !== '0) begin errors++; $display("FAIL abort_lvl: got %0d expected 0", sta_lvl); end
    checks++; if (sta_ufl !== STA) begin errors++; $display("FAIL abort_ufl_held: got %b expected %b", sta_ufl, STA); end
    run = 1'b1;
    tick;
    checks++; if (sta_ufl !== 1'b0) begin errors++; $display("FAIL abort_ufl_cleared: got %b expected 0", sta_ufl); end
    $display("tb: run abort done");
  endtask

  task automatic test_overflow;
    int i;
    logic e_rdy;
    logic [DW-1:0] e_dat;
    thr = 11'h7FF;
    for (int k = 0; k < 1024; k++) begin
      fs = (k == 0);
      wde = 1'b1;
      wdat = mk(k);
      tick;
      e_rdy = (k <= 1016);
      checks++; if (lbf_rdy !== e_rdy) begin errors++; $display("FAIL ovf_rdy k=%0d: got %b expected %b", k, lbf_rdy, e_rdy); end
      checks++; if (tg_run !== 1'b0) begin errors++; $display("FAIL ovf_tg_run_early k=%0d: got %b expected 0", k, tg_run); end
    end
    fs = 1'b0;
    wdat = mk(5000);
    tick;
    wde = 1'b0;
    checks++; if (sta_lvl !== exp_lvl(1024)) begin errors++; $display("FAIL ovf_lvl: got %0d expected %0d", sta_lvl, exp_lvl(1024)); end
    checks++; if (sta_ovf !== STA) begin errors++; $display("FAIL ovf_flag: got %b expected %b", sta_ovf, STA); end
    checks++; if (lbf_rdy !== 1'b0) begin errors++; $display("FAIL ovf_rdy_full: got %b expected 0", lbf_rdy); end
    tick;
    checks++; if (tg_run !== 1'b1) begin errors++; $display("FAIL ovf_thr_saturate: got %b expected 1", tg_run); end
    checks++; if (sta_ufl !== 1'b0) begin errors++; $display("FAIL ovf_ufl_clear: got %b expected 0", sta_ufl); end
    for (int c = 0; c < 1027; c++) begin
      tg_de = (c < 1026);
      tick;
      if (c >= 1) begin
        i = c - 1;
        e_dat = (i < 1024) ? mk(i) : '0;
        checks++; if ({q_de, q_dat} !== {1'b1, e_dat}) begin errors++; $display("FAIL ovf_readback i=%0d: got de=%b dat=%h expected de=1 dat=%h", i, q_de, q_dat, e_dat); end
      end
    end
    tg_de = 1'b0;
    checks++; if (sta_ufl !== STA) begin errors++; $display("FAIL ovf_drain_ufl: got %b expected %b", sta_ufl, STA); end
    $display("tb: overflow and ready done");
  endtask

  task automatic test_reset_midrun;
    for (int k = 0; k < 2; k++) begin
      wde = 1'b1;
      wdat = mk(300 + k);
      tick;
    end
    wde = 1'b0;
    tg_de = 1'b1;
    tick;
    tick;
    checks++; if ({tg_run, q_de} !== 2'b11) begin errors++; $display("FAIL midrun_active: got %b expected 11", {tg_run, q_de}); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({tg_run, lbf_rdy, q_vs, q_hs, q_de} !== 5'b0) begin errors++; $display("FAIL midrun_ctrl: got %b expected 00000", {tg_run, lbf_rdy, q_vs, q_hs, q_de}); end
    checks++; if (q_dat !== '0) begin errors++; $display("FAIL midrun_dat: got %h expected 0", q_dat); end
    checks++; if ({sta_lvl, sta_ufl, sta_ovf} !== '0) begin errors++; $display("FAIL midrun_sta: got %h expected 0", {sta_lvl, sta_ufl, sta_ovf}); end
    @(negedge clk);
    tg_de = 1'b0;
    rst = 1'b0;
    $display("tb: async reset done");
  endtask

  task automatic test_thr_zero;
    thr = '0;
    tick;
    fs = 1'b1;
    wde = 1'b1;
    wdat = mk(42);
    tick;
    fs = 1'b0;
    wde = 1'b0;
    tick;
    checks++; if (tg_run !== 1'b0) begin errors++; $display("FAIL thr0_entry: got %b expected 0", tg_run); end
    tick;
    checks++; if (tg_run !== 1'b1) begin errors++; $display("FAIL thr0_tg_run: got %b expected 1", tg_run); end
    tg_de = 1'b1;
    tick;
    tg_de = 1'b0;
    tick;
    checks++; if ({q_de, q_dat} !== {1'b1, mk(42)}) begin errors++; $display("FAIL thr0_word: got de=%b dat=%h expected de=1 dat=%h", q_de, q_dat, mk(42)); end
    $display("tb: zero threshold done");
  endtask

  initial begin
    test_reset;
    test_threshold;
    test_data_order;
    test_underflow;
    test_abort;
    test_overflow;
    test_reset_midrun;
    test_thr_zero;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
